// File: rtl/mem_wb_stage_pkg.sv
//============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the MEM/WB stage: load-type
//               codes, the "no store" byte-enable pattern and the MEM FSM
//               state encoding.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu_pkg;

    // Load type codes as carried on is_load_MEM; 3'b110/3'b111 mean no load
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_B    = 3'd2,
        LD_H    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } load_type_e;

    // Active-low byte write enables: all ones means no byte is written
    localparam logic [3:0] BWEB_NONE = 4'b1111;

    // MEM access FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RSP = 2'd1,
        ST_DONE     = 2'd2
    } mem_state_e;

    // True for the five load codes that actually request a read
    function automatic logic is_valid_load(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
//============================================================================
// Module      : mem_wb_stage_if
// Description : Data-memory request/response channel between the MEM stage
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mem_wb_stage_if;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_write;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_bweb;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;

    modport master (
        output dm_req_valid,
        output dm_req_write,
        output dm_req_addr,
        output dm_req_wdata,
        output dm_req_bweb,
        input  dm_req_ready,
        input  dm_rsp_valid,
        input  dm_rsp_rdata
    );

    modport slave (
        input  dm_req_valid,
        input  dm_req_write,
        input  dm_req_addr,
        input  dm_req_wdata,
        input  dm_req_bweb,
        output dm_req_ready,
        output dm_rsp_valid,
        output dm_rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
//============================================================================
// Module      : load_align
// Description : Combinational load data alignment. Shifts the addressed
//               byte lane down to bit 0 and sign/zero extends per load type.
//               Misaligned offsets are not trapped; bytes shifted in from
//               above the word read as zero before extension.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module load_align
    import cpu_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  offset,
    input  load_type_e       load_type,
    output logic      [31:0] data
);

    logic [31:0] w_sh;

    // Shift the addressed byte to lane 0, then extend to 32 bits
    always_comb begin
        w_sh = rdata >> {offset, 3'b000};
        data = 32'd0;
        case (load_type)
            LD_W:    data = w_sh;
            LD_B:    data = {{24{w_sh[7]}}, w_sh[7:0]};
            LD_H:    data = {{16{w_sh[15]}}, w_sh[15:0]};
            LD_BU:   data = {24'd0, w_sh[7:0]};
            LD_HU:   data = {16'd0, w_sh[15:0]};
            default: data = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
//============================================================================
// Module      : mem_wb_stage
// Description : Memory-access stage and MEM/WB pipeline register. Issues a
//               valid/ready data-memory request for loads and stores, aligns
//               returning load data, registers the write-back result and
//               stalls upstream stages while an access is outstanding.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_wb_stage
    import cpu_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,

    input  wire logic [31:0] alu_out_MEM,
    input  wire logic [31:0] store_data_MEM,
    input  wire logic [3:0]  DM_BWEB_MEM,
    input  wire logic [2:0]  is_load_MEM,
    input  wire logic [5:0]  rd_addr_MEM,
    input  wire logic        wb_en_MEM,
    input  wire logic        fwb_en_MEM,
    input  wire logic        hold_MEM,

    mem_wb_stage_if.master   dm,

    output logic             mem_stall,

    output logic      [5:0]  rd_addr_WB,
    output logic      [31:0] wb_data_WB,
    output logic             wb_en_WB,
    output logic             fwb_en_WB
);

    mem_state_e  r_state;
    mem_state_e  w_next_state;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_req_valid;
    logic        w_handshake;
    logic        w_stall;
    logic        w_load_done;

    logic [1:0]  r_offset;
    load_type_e  r_ld_type;
    logic [31:0] w_load_data;

    // Decode the access; a valid load code overrides any store enables
    always_comb begin
        w_is_load  = is_valid_load(is_load_MEM);
        w_is_store = !w_is_load && (DM_BWEB_MEM != BWEB_NONE);
        w_access   = w_is_load || w_is_store;
    end

    // Request fields follow the EX/MEM register directly
    assign dm.dm_req_addr  = {alu_out_MEM[31:2], 2'b00};
    assign dm.dm_req_wdata = store_data_MEM;
    assign dm.dm_req_bweb  = DM_BWEB_MEM;
    assign dm.dm_req_write = w_is_store;
    assign dm.dm_req_valid = w_req_valid;
    assign mem_stall       = w_stall;

    // Next-state, request valid, stall and load-completion decode
    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_handshake  = 1'b0;
        w_stall      = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Valid is masked during reset so nothing issues that cycle
                w_req_valid = w_access && !rst;
                w_handshake = w_req_valid && dm.dm_req_ready;
                if (w_access) begin
                    if (w_is_store && w_handshake) begin
                        // Store finishes on the handshake itself
                        w_next_state = hold_MEM ? ST_DONE : ST_IDLE;
                    end else begin
                        w_stall = 1'b1;
                        if (w_is_load && w_handshake) begin
                            w_next_state = ST_WAIT_RSP;
                        end
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (dm.dm_rsp_valid) begin
                    w_load_done  = 1'b1;
                    w_next_state = hold_MEM ? ST_DONE : ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_DONE: begin
                // Completed instruction still parked upstream: do not reissue
                if (!hold_MEM) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture byte offset and load type when the load request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset  <= 2'd0;
            r_ld_type <= LD_NONE;
        end else if (w_handshake && w_is_load) begin
            r_offset  <= alu_out_MEM[1:0];
            r_ld_type <= load_type_e'(is_load_MEM);
        end
    end

    load_align u_load_align (
        .rdata     (dm.dm_rsp_rdata),
        .offset    (r_offset),
        .load_type (r_ld_type),
        .data      (w_load_data)
    );

    // MEM/WB register: bubble while stalled or already completed
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_WB <= 6'd0;
            wb_data_WB <= 32'd0;
            wb_en_WB   <= 1'b0;
            fwb_en_WB  <= 1'b0;
        end else if (w_stall || (r_state == ST_DONE)) begin
            wb_en_WB   <= 1'b0;
            fwb_en_WB  <= 1'b0;
        end else begin
            rd_addr_WB <= rd_addr_MEM;
            wb_en_WB   <= wb_en_MEM;
            fwb_en_WB  <= fwb_en_MEM;
            wb_data_WB <= w_load_done ? w_load_data : alu_out_MEM;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
//============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage: directed scenarios
//               plus randomized ALU/load/store traffic against a byte-level
//               reference model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_MEM;
    logic [31:0] store_data_MEM;
    logic [3:0]  DM_BWEB_MEM;
    logic [2:0]  is_load_MEM;
    logic [5:0]  rd_addr_MEM;
    logic        wb_en_MEM;
    logic        fwb_en_MEM;
    logic        hold_MEM;
    logic        mem_stall;
    logic [5:0]  rd_addr_WB;
    logic [31:0] wb_data_WB;
    logic        wb_en_WB;
    logic        fwb_en_WB;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    mem_wb_stage_if dm ();

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .alu_out_MEM    (alu_out_MEM),
        .store_data_MEM (store_data_MEM),
        .DM_BWEB_MEM    (DM_BWEB_MEM),
        .is_load_MEM    (is_load_MEM),
        .rd_addr_MEM    (rd_addr_MEM),
        .wb_en_MEM      (wb_en_MEM),
        .fwb_en_MEM     (fwb_en_MEM),
        .hold_MEM       (hold_MEM),
        .dm             (dm.master),
        .mem_stall      (mem_stall),
        .rd_addr_WB     (rd_addr_WB),
        .wb_data_WB     (wb_data_WB),
        .wb_en_WB       (wb_en_WB),
        .fwb_en_WB      (fwb_en_WB)
    );

    always #5 clk = ~clk;

    // Count accepted requests as seen by the memory
    always @(posedge clk) begin
        if (!rst && dm.dm_req_valid && dm.dm_req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_out_MEM     = 32'd0;
        store_data_MEM  = 32'd0;
        DM_BWEB_MEM     = 4'b1111;
        is_load_MEM     = 3'd0;
        rd_addr_MEM     = 6'd0;
        wb_en_MEM       = 1'b0;
        fwb_en_MEM      = 1'b0;
        hold_MEM        = 1'b0;
        dm.dm_req_ready = 1'b0;
        dm.dm_rsp_valid = 1'b0;
        dm.dm_rsp_rdata = 32'd0;
    endtask

    // Reference: pick bytes from the word starting at the offset (zero past
    // the top), then take the access width and extend
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                             input logic [2:0] kind);
        logic [7:0] b [4];
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx  = int'(off) + k;
            b[k] = (idx < 4) ? d[8*idx +: 8] : 8'h00;
        end
        case (kind)
            3'd1:    return {b[3], b[2], b[1], b[0]};
            3'd2:    return {{24{b[0][7]}}, b[0]};
            3'd3:    return {{16{b[1][7]}}, b[1], b[0]};
            3'd4:    return {24'd0, b[0]};
            3'd5:    return {16'd0, b[1], b[0]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_alu(input logic [31:0] v, input logic [5:0] rd, input logic we,
                          input logic fwe, input logic junk_rsp);
        @(negedge clk);
        idle_inputs();
        alu_out_MEM     = v;
        rd_addr_MEM     = rd;
        wb_en_MEM       = we;
        fwb_en_MEM      = fwe;
        dm.dm_rsp_valid = junk_rsp;
        dm.dm_rsp_rdata = $urandom;
        #1;
        chk("alu_stall", 32'(mem_stall), 32'd0);
        chk("alu_req_valid", 32'(dm.dm_req_valid), 32'd0);
        @(posedge clk); #1;
        chk("alu_wb_data", wb_data_WB, v);
        chk("alu_rd", 32'(rd_addr_WB), 32'(rd));
        chk("alu_wb_en", 32'(wb_en_WB), 32'(we));
        chk("alu_fwb_en", 32'(fwb_en_WB), 32'(fwe));
    endtask

    task automatic do_load(input logic [2:0] kind, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [5:0] rd, input logic we, input logic fwe,
                           input int rdy_dly, input int lat);
        int hs0;
        @(negedge clk);
        idle_inputs();
        alu_out_MEM = addr;
        is_load_MEM = kind;
        rd_addr_MEM = rd;
        wb_en_MEM   = we;
        fwb_en_MEM  = fwe;
        hs0 = hs_cnt;
        for (int i = 0; i < rdy_dly; i++) begin
            #1;
            chk("ld_wait_valid", 32'(dm.dm_req_valid), 32'd1);
            chk("ld_wait_addr", dm.dm_req_addr, {addr[31:2], 2'b00});
            chk("ld_wait_stall", 32'(mem_stall), 32'd1);
            @(negedge clk);
        end
        dm.dm_req_ready = 1'b1;
        #1;
        chk("ld_req_valid", 32'(dm.dm_req_valid), 32'd1);
        chk("ld_req_write", 32'(dm.dm_req_write), 32'd0);
        chk("ld_hs_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        dm.dm_req_ready = 1'b0;
        for (int i = 0; i < lat - 1; i++) begin
            #1;
            chk("ld_rsp_stall", 32'(mem_stall), 32'd1);
            chk("ld_rsp_valid_off", 32'(dm.dm_req_valid), 32'd0);
            chk("ld_bubble", 32'(wb_en_WB | fwb_en_WB), 32'd0);
            @(negedge clk);
        end
        dm.dm_rsp_valid = 1'b1;
        dm.dm_rsp_rdata = rdata;
        #1;
        chk("ld_done_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("ld_wb_data", wb_data_WB, ref_load(rdata, addr[1:0], kind));
        chk("ld_rd", 32'(rd_addr_WB), 32'(rd));
        chk("ld_wb_en", 32'(wb_en_WB), 32'(we));
        chk("ld_fwb_en", 32'(fwb_en_WB), 32'(fwe));
        chk("ld_handshakes", 32'(hs_cnt - hs0), 32'd1);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] bweb, input logic [31:0] wdata,
                            input int rdy_dly, input int hold_cyc, input logic we);
        int hs0;
        @(negedge clk);
        idle_inputs();
        alu_out_MEM    = addr;
        store_data_MEM = wdata;
        DM_BWEB_MEM    = bweb;
        wb_en_MEM      = we;
        rd_addr_MEM    = 6'($urandom);
        hs0 = hs_cnt;
        for (int i = 0; i < rdy_dly; i++) begin
            #1;
            chk("st_wait_valid", 32'(dm.dm_req_valid), 32'd1);
            chk("st_wait_write", 32'(dm.dm_req_write), 32'd1);
            chk("st_wait_addr", dm.dm_req_addr, {addr[31:2], 2'b00});
            chk("st_wait_wdata", dm.dm_req_wdata, wdata);
            chk("st_wait_bweb", 32'(dm.dm_req_bweb), 32'(bweb));
            chk("st_wait_stall", 32'(mem_stall), 32'd1);
            @(negedge clk);
        end
        dm.dm_req_ready = 1'b1;
        hold_MEM        = (hold_cyc > 0);
        #1;
        chk("st_req_valid", 32'(dm.dm_req_valid), 32'd1);
        chk("st_hs_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("st_wb_en", 32'(wb_en_WB), 32'(we));
        for (int i = 0; i < hold_cyc; i++) begin
            @(negedge clk);
            hold_MEM = (i < hold_cyc - 1);
            #1;
            chk("st_held_valid", 32'(dm.dm_req_valid), 32'd0);
            chk("st_held_stall", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            chk("st_held_wb_en", 32'(wb_en_WB), 32'd0);
        end
        chk("st_handshakes", 32'(hs_cnt - hs0), 32'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset with a load presented: no request may issue
        @(negedge clk);
        is_load_MEM = 3'd1;
        #1;
        chk("rst_req_valid", 32'(dm.dm_req_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_wb_data", wb_data_WB, 32'd0);
        chk("rst_rd", 32'(rd_addr_WB), 32'd0);
        chk("rst_en", 32'({wb_en_WB, fwb_en_WB}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Directed scenarios
        do_alu(32'h1234_5678, 6'd5, 1'b1, 1'b0, 1'b0);
        do_load(3'd2, 32'h0000_0103, 32'h80AA_BBCC, 6'd7, 1'b1, 1'b0, 0, 2);
        do_load(3'd5, 32'h0000_0102, 32'h80AA_BBCC, 6'd8, 1'b1, 1'b0, 0, 2);
        do_load(3'd1, 32'h0000_0200, 32'hDEAD_BEEF, 6'h21, 1'b0, 1'b1, 0, 1);
        do_store(32'h0000_0101, 4'b1101, 32'h0000_5A00, 3, 0, 1'b0);
        do_store(32'h0000_0300, 4'b0000, 32'hCAFE_F00D, 0, 2, 1'b1);
        do_alu(32'h0BAD_F00D, 6'd9, 1'b1, 1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: do_alu($urandom, 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                1: do_load(3'($urandom_range(1, 5)), $urandom, $urandom, 6'($urandom),
                           1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(1, 3));
                default: do_store($urandom, 4'($urandom_range(0, 14)), $urandom,
                                  $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
            endcase
        end

        // Make the WB register non-zero before the mid-transaction reset
        do_alu(32'h5555_AAAA, 6'd3, 1'b1, 1'b1, 1'b0);

        // Reset while waiting for a load response; late response ignored
        @(negedge clk);
        idle_inputs();
        alu_out_MEM     = 32'h0000_0400;
        is_load_MEM     = 3'd1;
        rd_addr_MEM     = 6'd12;
        wb_en_MEM       = 1'b1;
        dm.dm_req_ready = 1'b1;
        @(negedge clk);
        dm.dm_req_ready = 1'b0;
        #1;
        chk("mid_wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(dm.dm_req_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_wb_data", wb_data_WB, 32'd0);
        chk("mid_rst_rd", 32'(rd_addr_WB), 32'd0);
        chk("mid_rst_en", 32'({wb_en_WB, fwb_en_WB}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        dm.dm_rsp_valid = 1'b1;
        dm.dm_rsp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("late_rsp_valid", 32'(dm.dm_req_valid), 32'd0);
        @(posedge clk); #1;
        chk("late_rsp_wb_en", 32'({wb_en_WB, fwb_en_WB}), 32'd0);
        chk("late_rsp_wb_data", wb_data_WB, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
